// File: rtl/fp_wb_scheduler_if.sv
// Bundle of issue, operand-check, write-back request and register-file write signals
// for the FP write-back scheduler.
interface fp_wb_scheduler_if;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rs3_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rs3_busy;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wr_data;
    logic [31:0] busy_mask;
    logic        stray_wb;

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr, rs3_addr,
               req_valid, req_rd, req_data,
        input  issue_ready, rs1_busy, rs2_busy, rs3_busy, req_ready,
               rf_wr_en, rf_rd_addr, rf_wr_data, busy_mask, stray_wb
    );

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr, rs3_addr,
               req_valid, req_rd, req_data,
        output issue_ready, rs1_busy, rs2_busy, rs3_busy, req_ready,
               rf_wr_en, rf_rd_addr, rf_wr_data, busy_mask, stray_wb
    );
endinterface

// File: rtl/fp_wb_scheduler.sv
// FP write-back arbiter and WAW scoreboard. Define FP_WB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise requester 0 > 1 > 2 fixed priority.
module fp_wb_scheduler (
    input  logic             clk,
    input  logic             rst,
    fp_wb_scheduler_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic [2:0]        grant;
    logic [1:0]        grant_idx;
    logic              wb_hs;
    logic              issue_hs;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [31:0]       busy_q;
    logic [31:0]       set_mask;
    logic [31:0]       clr_mask;
    logic              stray_q;
    logic              stray_hit;
    logic              vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;

    function automatic logic [2:0] fixed_pick(input logic [2:0] vld);
        if (vld[0])      return 3'b001;
        else if (vld[1]) return 3'b010;
        else if (vld[2]) return 3'b100;
        else             return 3'b000;
    endfunction

`ifdef FP_WB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    // Rotate so the pointed-to requester sits at bit 0, pick, then rotate back.
    function automatic logic [2:0] rr_pick(input logic [2:0] vld, input logic [1:0] ptr);
        logic [2:0] rot;
        logic [2:0] g;
        case (ptr)
            2'd1:    rot = {vld[0], vld[2], vld[1]};
            2'd2:    rot = {vld[1], vld[0], vld[2]};
            default: rot = vld;
        endcase
        g = fixed_pick(rot);
        case (ptr)
            2'd1:    return {g[1], g[0], g[2]};
            2'd2:    return {g[0], g[2], g[1]};
            default: return g;
        endcase
    endfunction

    assign grant = rr_pick(bus.req_valid, rr_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (wb_hs) begin
            rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end
    end
`else
    assign grant = fixed_pick(bus.req_valid);
`endif

    always_comb begin
        grant_idx = 2'd0;
        sel_rd    = bus.req_rd[4:0];
        sel_data  = bus.req_data[31:0];
        case (grant)
            3'b010: begin
                grant_idx = 2'd1;
                sel_rd    = bus.req_rd[9:5];
                sel_data  = bus.req_data[63:32];
            end
            3'b100: begin
                grant_idx = 2'd2;
                sel_rd    = bus.req_rd[14:10];
                sel_data  = bus.req_data[95:64];
            end
            default: ;
        endcase
    end

    assign bus.req_ready   = rst ? 3'b000 : grant;
    assign wb_hs           = |bus.req_ready;
    assign bus.issue_ready = ~rst & ~busy_q[bus.issue_rd];
    assign issue_hs        = bus.issue_valid & bus.issue_ready;

    // An issue needs its bit clear while a clear needs its bit set, so the two masks never overlap.
    assign set_mask  = issue_hs ? (32'd1 << bus.issue_rd) : 32'd0;
    assign clr_mask  = (vld_p1 && busy_q[wr_addr_p1]) ? (32'd1 << wr_addr_p1) : 32'd0;
    assign stray_hit = vld_p1 & ~busy_q[wr_addr_p1];

    // p0 -> p1: granted write-back captured for the register-file write port
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            busy_q     <= '0;
            stray_q    <= 1'b0;
        end else begin
            vld_p1 <= wb_hs;
            if (wb_hs) begin
                wr_addr_p1 <= sel_rd;
                wr_data_p1 <= sel_data;
            end
            busy_q <= (busy_q | set_mask) & ~clr_mask;
            if (stray_hit) begin
                stray_q <= 1'b1;
            end
        end
    end

    // Outputs read as zero during reset so a write held from before reset never reaches the file.
    assign bus.rf_wr_en   = vld_p1 & ~rst;
    assign bus.rf_rd_addr = rst ? '0 : wr_addr_p1;
    assign bus.rf_wr_data = rst ? '0 : wr_data_p1;
    assign bus.busy_mask  = rst ? '0 : busy_q;
    assign bus.stray_wb   = stray_q & ~rst;
    assign bus.rs1_busy   = bus.busy_mask[bus.rs1_addr];
    assign bus.rs2_busy   = bus.busy_mask[bus.rs2_addr];
    assign bus.rs3_busy   = bus.busy_mask[bus.rs3_addr];
endmodule

// File: tb/tb_fp_wb_scheduler.sv
// Bench for fp_wb_scheduler: directed scenarios then random traffic against a
// pending-set / write-queue reference model.
module tb_fp_wb_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_wb_scheduler_if bus_if();

    fp_wb_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    bit        m_pend[32];
    bit        m_stray;
    bit        m_en;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    int        m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] pend_vec();
        bit [31:0] v;
        for (int n = 0; n < 32; n++) v[n] = m_pend[n];
        return v;
    endfunction

    function automatic bit [2:0] exp_grant(input bit [2:0] v);
        int start;
`ifdef FP_WB_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (start + k) % 3;
            if (v[i]) return 3'b001 << i;
        end
        return 3'b000;
    endfunction

    // Drive one cycle of inputs at the falling edge, check, then advance the model past the rising edge.
    task automatic step(input bit r, input bit [2:0] rv, input bit [14:0] rrd, input bit [95:0] rdat,
                        input bit iv, input bit [4:0] ird,
                        input bit [4:0] a1, input bit [4:0] a2, input bit [4:0] a3);
        bit [2:0]  g;
        bit [31:0] pv;
        int        idx;
        rst                = r;
        bus_if.req_valid   = rv;
        bus_if.req_rd      = rrd;
        bus_if.req_data    = rdat;
        bus_if.issue_valid = iv;
        bus_if.issue_rd    = ird;
        bus_if.rs1_addr    = a1;
        bus_if.rs2_addr    = a2;
        bus_if.rs3_addr    = a3;
        #1;
        pv = pend_vec();
        g  = r ? 3'b000 : exp_grant(rv);
        chk("rf_wr_en",    bus_if.rf_wr_en,    r ? 32'd0 : 32'(m_en));
        chk("rf_rd_addr",  bus_if.rf_rd_addr,  r ? 32'd0 : 32'(m_addr));
        chk("rf_wr_data",  bus_if.rf_wr_data,  r ? 32'd0 : m_data);
        chk("busy_mask",   bus_if.busy_mask,   r ? 32'd0 : pv);
        chk("stray_wb",    bus_if.stray_wb,    r ? 32'd0 : 32'(m_stray));
        chk("req_ready",   bus_if.req_ready,   32'(g));
        chk("issue_ready", bus_if.issue_ready, (r || pv[ird]) ? 32'd0 : 32'd1);
        chk("rs1_busy",    bus_if.rs1_busy,    r ? 32'd0 : 32'(pv[a1]));
        chk("rs2_busy",    bus_if.rs2_busy,    r ? 32'd0 : 32'(pv[a2]));
        chk("rs3_busy",    bus_if.rs3_busy,    r ? 32'd0 : 32'(pv[a3]));
        @(posedge clk);
        if (r) begin
            for (int n = 0; n < 32; n++) m_pend[n] = 1'b0;
            m_stray = 1'b0;
            m_en    = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_ptr   = 0;
        end else begin
            if (m_en) begin
                if (pv[m_addr]) m_pend[m_addr] = 1'b0;
                else            m_stray = 1'b1;
            end
            if (iv && !pv[ird]) m_pend[ird] = 1'b1;
            m_en = (g != 3'b000);
            if (m_en) begin
                idx = g[0] ? 0 : (g[1] ? 1 : 2);
                m_addr = rrd[5*idx +: 5];
                m_data = rdat[32*idx +: 32];
                m_ptr  = (idx + 1) % 3;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        bus_if.req_valid   = '0;
        bus_if.req_rd      = '0;
        bus_if.req_data    = '0;
        bus_if.issue_valid = 1'b0;
        bus_if.issue_rd    = '0;
        bus_if.rs1_addr    = '0;
        bus_if.rs2_addr    = '0;
        bus_if.rs3_addr    = '0;
        m_stray = 1'b0; m_en = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
        for (int n = 0; n < 32; n++) m_pend[n] = 1'b0;
        @(negedge clk);

        // reset, with a request and an issue presented that must be discarded
        step(1'b1, 3'b001, {10'd0, 5'd3}, 96'd5, 1'b1, 5'd3, 5'd3, 5'd0, 5'd0);
        step(1'b1, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        idle(1);

        // issue rd=5, then FMA write-back of 1.0f to f5
        step(1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 5'd5, 5'd7, 5'd0);
        step(1'b0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'h3F800000, 32'd0}, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
        chk("wb5_en",   bus_if.rf_wr_en,   32'd1);
        chk("wb5_addr", bus_if.rf_rd_addr, 32'd5);
        chk("wb5_data", bus_if.rf_wr_data, 32'h3F800000);
        chk("wb5_busy_still_set", bus_if.busy_mask[5], 32'd1);
        idle(1);
        chk("wb5_busy_cleared", bus_if.busy_mask[5], 32'd0);

        // WAW stall on f7 until its write-back commits
        step(1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 5'd7, 5'd7);
        step(1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 5'd0, 5'd0);
        step(1'b0, 3'b100, {5'd7, 10'd0}, {32'h40490FDB, 64'd0}, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
        step(1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
        chk("waw7_ready_after_commit", bus_if.issue_ready, 32'd1);
        step(1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
        step(1'b0, 3'b100, {5'd7, 10'd0}, {32'h1, 64'd0}, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        idle(2);

        // all three requesters held valid for three cycles
        for (int c = 0; c < 3; c++)
            step(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000},
                 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        idle(1);

        // reset, then a stray write-back to f9
        step(1'b1, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 3'b001, {10'd0, 5'd9}, {64'd0, 32'h12345678}, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
        idle(1);
        chk("stray9_set", bus_if.stray_wb, 32'd1);
        chk("stray9_mask_unchanged", bus_if.busy_mask, 32'd0);
        idle(2);

        // handshake immediately followed by reset: the pending write is dropped
        step(1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd4, 5'd0, 5'd0, 5'd0);
        step(1'b0, 3'b010, {5'd0, 5'd4, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 1'b0, 5'd0, 5'd4, 5'd0, 5'd0);
        step(1'b1, 3'b000, 15'd0, 96'd0, 1'b1, 5'd6, 5'd0, 5'd0, 5'd0);
        idle(1);
        chk("rst_drop_wr_en", bus_if.rf_wr_en, 32'd0);
        chk("rst_drop_busy",  bus_if.busy_mask, 32'd0);

        // random traffic over a small register window to force collisions
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 59) == 0),
                 3'($urandom_range(0, 7)),
                 {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                 {$urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_wb_scheduler.md
FP_WB_SCHEDULER -- requirements
Module: fp_wb_scheduler

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports issue_valid input 1 and issue_rd input 5: an FP instruction with destination issue_rd is issuing.
REQ-004 SHALL have port issue_ready  output  1  issue accepted (combinational).
REQ-005 SHALL have ports rs1_addr, rs2_addr, rs3_addr  input  5 each: operand addresses to check.
REQ-006 SHALL have ports rs1_busy, rs2_busy, rs3_busy  output  1 each: operand has a pending write (combinational).
REQ-007 SHALL have ports req_valid input 3, req_rd input 15 (5 bits per requester, requester i in bits 5i+4:5i), req_data input 96 (32 bits per requester, requester i in bits 32i+31:32i): write-back requests; requester 0 is FP load, requester 1 is FMA pipe, requester 2 is FDIV/FSQRT.
REQ-008 SHALL have port req_ready  output  3  one-hot grant (combinational).
REQ-009 SHALL have ports rf_wr_en output 1, rf_rd_addr output 5 and rf_wr_data output 32, all registered, driving the FP register file write port.
REQ-010 SHALL have port busy_mask  output  32  scoreboard state; bit n set means fn has a write pending.
REQ-011 SHALL have port stray_wb  output  1  sticky error flag.

Function
REQ-012 A requester i handshake occurs when req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high in any cycle.
REQ-013 req_ready[i] SHALL be high only when req_valid[i] is high and requester i wins arbitration; it SHALL NOT depend on req_ready.
REQ-014 On a handshake, the granted rd and data SHALL appear on rf_rd_addr and rf_wr_data with rf_wr_en=1 in the next cycle (1-cycle latency).
REQ-015 rf_wr_en SHALL be 0 in any cycle that does not follow a handshake; rf_rd_addr and rf_wr_data SHALL hold their last values when rf_wr_en is 0.
REQ-016 issue_ready SHALL equal NOT busy_mask[issue_rd]; this stalls WAW hazards.
REQ-017 On an issue handshake, busy_mask[issue_rd] SHALL be set at the next edge.
REQ-018 In a cycle where rf_wr_en=1 and busy_mask[rf_rd_addr]=1, that bit SHALL be cleared at the next edge; register-file reads in the following cycle see the new data.
REQ-019 Set and clear of the same bit in one cycle SHALL be impossible by construction (REQ-016); set and clear of different bits in one cycle SHALL both take effect.
REQ-020 rsK_busy SHALL equal busy_mask[rsK_addr] for K = 1, 2, 3.
REQ-021 If rf_wr_en=1 and busy_mask[rf_rd_addr]=0, the register file write SHALL still occur, no scoreboard bit SHALL change, and stray_wb SHALL set and remain set until reset.
REQ-022 Non-granted requesters SHALL hold req_valid and their payload; the block SHALL NOT buffer them.

Reset
REQ-023 While rst=1: busy_mask=0, rf_wr_en=0, rf_rd_addr=0, rf_wr_data=0, stray_wb=0, round-robin pointer=0, req_ready=0 and issue_ready=0.
REQ-024 Requests and issues presented in the reset cycle SHALL be discarded; a write pending in the output register at reset SHALL be dropped.

Configuration
REQ-025 Macro FP_WB_ROUND_ROBIN_EN defined: arbitration SHALL be round-robin; the search starts at the requester after the last granted one, and the pointer updates only on a handshake.
REQ-026 Macro FP_WB_ROUND_ROBIN_EN undefined: arbitration SHALL be fixed priority, requester 0 > 1 > 2, with no pointer state.

Verification
REQ-027 Issue rd=5, then FMA write-back rd=5 data 0x3F800000 -> rf_wr_en=1 with addr 5 and data 0x3F800000 one cycle later; busy_mask[5] clears the following cycle.
REQ-028 busy_mask[7]=1 and issue_rd=7 -> issue_ready=0 until the rd=7 write-back commits, then issue_ready=1.
REQ-029 req_valid=3'b111 held for 3 cycles -> RR build: grants 0,1,2 in order; fixed-priority build: grant 0 in all 3 cycles.
REQ-030 Write-back to rd=9 with busy_mask[9]=0 -> register write occurs, busy_mask unchanged, stray_wb=1 and sticky.
REQ-031 rst asserted the cycle after a handshake -> rf_wr_en=0, busy_mask=0, stray_wb=0; no write reaches the register file.
